// File: rtl/a_channel_if.sv
// Signal bundle between the OBI master / cache controller side and the a_channel
// request front end. The slave modport is the a_channel view.
interface a_channel_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  obi_req_i;
   logic [ADDR_WIDTH-1:0] obi_addr_i;
   logic                  obi_we_i;
   logic [BE_WIDTH-1:0]   obi_be_i;
   logic [DATA_WIDTH-1:0] obi_wdata_i;
   logic                  obi_gnt_o;
   logic                  internal_gnt_o;

   logic                  ctrl_valid_o;
   logic [ADDR_WIDTH-1:0] ctrl_addr_o;
   logic                  ctrl_we_o;
   logic [BE_WIDTH-1:0]   ctrl_be_o;
   logic [DATA_WIDTH-1:0] ctrl_wdata_o;
   logic                  ctrl_ready_i;
   logic                  ctrl_done_i;
   logic [DATA_WIDTH-1:0] ctrl_rdata_i;
   logic                  ctrl_err_i;

   logic                  rvalid_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  err_o;

   modport slave (
      input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
      output obi_gnt_o, internal_gnt_o,
      output ctrl_valid_o, ctrl_addr_o, ctrl_we_o, ctrl_be_o, ctrl_wdata_o,
      input  ctrl_ready_i, ctrl_done_i, ctrl_rdata_i, ctrl_err_i,
      output rvalid_o, rdata_o, err_o
   );

   modport master (
      output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
      input  obi_gnt_o, internal_gnt_o,
      input  ctrl_valid_o, ctrl_addr_o, ctrl_we_o, ctrl_be_o, ctrl_wdata_o,
      output ctrl_ready_i, ctrl_done_i, ctrl_rdata_i, ctrl_err_i,
      input  rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/a_channel.sv
// OBI A-channel front end: grants one request at a time, hands it to the cache
// controller, and emits a one-cycle response with alignment and timeout errors.
//
//   state | meaning
//   IDLE  | granting; capture request on obi_req_i
//   ISSUE | ctrl_valid_o high, waiting for ctrl_ready_i
//   WAIT  | handshake done, waiting for ctrl_done_i
//   RESP  | rvalid_o pulse for one cycle
module a_channel #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic       clk,
   input logic       rst_n,
   a_channel_if.slave bus
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BE_WIDTH - 1);

   logic [1:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [BE_WIDTH-1:0]   be_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic                  aligned;

   // Mask form keeps the check legal when BE_WIDTH is 1 (no offset bits).
   assign aligned = (bus.obi_addr_i & ALIGN_MASK) == '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.obi_req_i) begin
                  addr_q  <= bus.obi_addr_i;
                  we_q    <= bus.obi_we_i;
                  be_q    <= bus.obi_be_i;
                  wdata_q <= bus.obi_wdata_i;
                  cnt     <= '0;
                  if (aligned) begin
                     state <= ISSUE;
                  end else begin
                     state   <= RESP;
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               cnt <= cnt + 1'b1;
               if (bus.ctrl_ready_i && bus.ctrl_done_i) begin
                  state   <= RESP;
                  rdata_q <= we_q ? '0 : bus.ctrl_rdata_i;
                  err_q   <= bus.ctrl_err_i;
               end else if (cnt == CNT_LAST) begin
                  state   <= RESP;
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end else if (bus.ctrl_ready_i) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (bus.ctrl_done_i) begin
                  state   <= RESP;
                  rdata_q <= we_q ? '0 : bus.ctrl_rdata_i;
                  err_q   <= bus.ctrl_err_i;
               end else if (cnt == CNT_LAST) begin
                  state   <= RESP;
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.obi_gnt_o      = (state == IDLE);
   assign bus.internal_gnt_o = (state == IDLE);
   assign bus.ctrl_valid_o   = (state == ISSUE);
   assign bus.ctrl_addr_o    = addr_q;
   assign bus.ctrl_we_o      = we_q;
   assign bus.ctrl_be_o      = be_q;
   assign bus.ctrl_wdata_o   = wdata_q;
   assign bus.rvalid_o       = (state == RESP);
   assign bus.rdata_o        = rdata_q;
   assign bus.err_o          = err_q;
endmodule
